multicycle_control: RTL

Multi-cycle main control unit for the MIPS CPU. A registered FSM sequences each instruction through fetch, decode, execute, memory and writeback over a shared memory port with a ready handshake. It drives the multi-cycle datapath muxes and enables, and traps on illegal opcodes and memory timeouts. It replaces the single-cycle combinational decoder when the core runs from one unified, variable-latency memory.

---
 rtl/mips_ctl_pkg.sv | 58 +++++
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// opcodes, FSM state encoding and datapath mux select values.
package mips_ctl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned CNT_W    = 8;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMRD    = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWR    = 4'd6,
        ST_RTYPE_EX = 4'd7,
        ST_RTYPE_WB = 4'd8,
        ST_ADDI_EX  = 4'd9,
        ST_ADDI_WB  = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_JAL      = 4'd13,
        ST_TRAP     = 4'd15
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // States that own the shared memory port.
    function automatic logic is_mem_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the main control FSM (master) and the
// multi-cycle datapath plus unified memory (slave).
interface multicycle_control_if;
    import mips_ctl_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                stall_in;

    logic                mem_req;
    logic                mem_we;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic                regwrite;
    logic                memtoreg;
    logic [1:0]          regdst;
    logic                alusrc_a;
    logic [1:0]          alusrc_b;
    logic [1:0]          aluop;
    logic [1:0]          pcsrc;
    logic [STATE_W-1:0]  state;
    logic                busy;
    logic                illegal;
    logic                mem_timeout;

    modport master (
        input  opcode, zero, mem_ready, stall_in,
        output mem_req, mem_we, iord, ir_write, pc_write, regwrite, memtoreg,
               regdst, alusrc_a, alusrc_b, aluop, pcsrc, state, busy,
               illegal, mem_timeout
    );

    modport slave (
        output opcode, zero, mem_ready, stall_in,
        input  mem_req, mem_we, iord, ir_write, pc_write, regwrite, memtoreg,
               regdst, alusrc_a, alusrc_b, aluop, pcsrc, state, busy,
               illegal, mem_timeout
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; terminal_c flags the wait cycle that would
// bring the count up to MEM_TIMEOUT.
module mem_wait_timer
    import mips_ctl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic hold,
    output logic terminal_c
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && !hold) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign terminal_c = count_en && !hold && (count_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory ready handshake and traps.
// Optional feature: define MCTL_JAL_EN to make opcode 000011 (jal) legal.
module multicycle_control
    import mips_ctl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctl
);

    state_t              state_q, state_n;
    logic [OPCODE_W-1:0] op_q;
    logic                illegal_q, timeout_q;
    logic                set_illegal_c, set_timeout_c;
    logic                stall_c, req_c, xfer_c, wait_c, term_c, clear_c;
    logic                mem_we_c, iord_c, ir_write_c, pc_write_c;
    logic                regwrite_c, memtoreg_c, alusrc_a_c;
    logic [1:0]          regdst_c, alusrc_b_c, aluop_c, pcsrc_c;

    assign stall_c = ctl.stall_in;
    assign req_c   = is_mem_state(state_q) && !stall_c;
    assign xfer_c  = req_c && ctl.mem_ready;
    assign wait_c  = req_c && !ctl.mem_ready;
    assign clear_c = (state_n != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_c),
        .count_en  (wait_c),
        .hold      (stall_c),
        .terminal_c(term_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_n;
        end
    end

    // Opcode latch for branch polarity and lw/sw split, plus sticky trap causes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_DECODE && !stall_c) begin
                op_q <= ctl.opcode;
            end
            illegal_q <= illegal_q | set_illegal_c;
            timeout_q <= timeout_q | set_timeout_c;
        end
    end

    always_comb begin
        state_n       = state_q;
        set_illegal_c = 1'b0;
        set_timeout_c = 1'b0;
        mem_we_c      = 1'b0;
        iord_c        = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        regwrite_c    = 1'b0;
        memtoreg_c    = 1'b0;
        alusrc_a_c    = 1'b0;
        regdst_c      = REGDST_RT;
        alusrc_b_c    = SRCB_B;
        aluop_c       = ALUOP_ADD;
        pcsrc_c       = PCSRC_ALU;

        case (state_q)
            ST_RESET: state_n = ST_FETCH;
            ST_FETCH: begin
                alusrc_b_c = SRCB_FOUR;
                ir_write_c = xfer_c;
                pc_write_c = xfer_c;
                if (xfer_c) begin
                    state_n = ST_DECODE;
                end else if (term_c) begin
                    state_n       = ST_TRAP;
                    set_timeout_c = 1'b1;
                end
            end
            ST_DECODE: begin
                alusrc_b_c = SRCB_IMM_SH2;
                case (ctl.opcode)
                    OP_LW, OP_SW:   state_n = ST_MEMADR;
                    OP_RTYPE:       state_n = ST_RTYPE_EX;
                    OP_ADDI:        state_n = ST_ADDI_EX;
                    OP_BEQ, OP_BNE: state_n = ST_BRANCH;
                    OP_J:           state_n = ST_JUMP;
`ifdef MCTL_JAL_EN
                    OP_JAL:         state_n = ST_JAL;
`endif
                    default: begin
                        state_n       = ST_TRAP;
                        set_illegal_c = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                alusrc_a_c = 1'b1;
                alusrc_b_c = SRCB_IMM;
                state_n    = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                iord_c = 1'b1;
                if (xfer_c) begin
                    state_n = ST_MEMWB;
                end else if (term_c) begin
                    state_n       = ST_TRAP;
                    set_timeout_c = 1'b1;
                end
            end
            ST_MEMWR: begin
                iord_c   = 1'b1;
                mem_we_c = 1'b1;
                if (xfer_c) begin
                    state_n = ST_FETCH;
                end else if (term_c) begin
                    state_n       = ST_TRAP;
                    set_timeout_c = 1'b1;
                end
            end
            ST_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                state_n    = ST_FETCH;
            end
            ST_RTYPE_EX: begin
                alusrc_a_c = 1'b1;
                aluop_c    = ALUOP_FUNCT;
                state_n    = ST_RTYPE_WB;
            end
            ST_RTYPE_WB: begin
                regwrite_c = 1'b1;
                regdst_c   = REGDST_RD;
                state_n    = ST_FETCH;
            end
            ST_ADDI_EX: begin
                alusrc_a_c = 1'b1;
                alusrc_b_c = SRCB_IMM;
                state_n    = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                regwrite_c = 1'b1;
                state_n    = ST_FETCH;
            end
            ST_BRANCH: begin
                alusrc_a_c = 1'b1;
                aluop_c    = ALUOP_SUB;
                pcsrc_c    = PCSRC_ALUOUT;
                pc_write_c = (op_q == OP_BEQ) ? ctl.zero : !ctl.zero;
                state_n    = ST_FETCH;
            end
            ST_JUMP: begin
                pcsrc_c    = PCSRC_JUMP;
                pc_write_c = 1'b1;
                state_n    = ST_FETCH;
            end
            ST_JAL: begin
                regwrite_c = 1'b1;
                regdst_c   = REGDST_RA;
                pcsrc_c    = PCSRC_JUMP;
                pc_write_c = 1'b1;
                state_n    = ST_FETCH;
            end
            ST_TRAP: state_n = ST_TRAP;
            default: state_n = ST_TRAP;
        endcase

        // External hold freezes the sequence and suppresses every side effect.
        if (stall_c && state_q != ST_RESET) begin
            state_n       = state_q;
            set_illegal_c = 1'b0;
            set_timeout_c = 1'b0;
            mem_we_c      = 1'b0;
            ir_write_c    = 1'b0;
            pc_write_c    = 1'b0;
            regwrite_c    = 1'b0;
        end
    end

    assign ctl.mem_req     = req_c;
    assign ctl.mem_we      = mem_we_c;
    assign ctl.iord        = iord_c;
    assign ctl.ir_write    = ir_write_c;
    assign ctl.pc_write    = pc_write_c;
    assign ctl.regwrite    = regwrite_c;
    assign ctl.memtoreg    = memtoreg_c;
    assign ctl.regdst      = regdst_c;
    assign ctl.alusrc_a    = alusrc_a_c;
    assign ctl.alusrc_b    = alusrc_b_c;
    assign ctl.aluop       = aluop_c;
    assign ctl.pcsrc       = pcsrc_c;
    assign ctl.state       = state_q;
    assign ctl.busy        = (state_q != ST_RESET) && (state_q != ST_TRAP);
    assign ctl.illegal     = illegal_q;
    assign ctl.mem_timeout = timeout_q;

endmodule
